age_issue_queue: RTL

//  Parametrised unified issue queue: internal entry allocation, CAM wakeup, ROB-age flush on mispredict.

---
 rtl/age_issue_queue.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/age_issue_queue.sv
// Unified issue queue: lowest-free-entry allocation, CAM wakeup, per-port select, ROB-age flush.
// Optional macro IQ_AGE_SELECT_EN: oldest-first select per port (default: lowest index first).
module age_issue_queue #(
  parameter int IQ_ENT    = 16,
  parameter int DP_W      = 2,
  parameter int ISSUE_W   = 3,
  parameter int WB_W      = 3,
  parameter int TAG_W     = 7,
  parameter int ROB_W     = 6,
  parameter int PAYLOAD_W = 32,
  localparam int IQ_SEL   = $clog2(IQ_ENT),
  localparam int PORT_W   = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DP_W-1:0]                dp_valid,
  input  logic [DP_W*PORT_W-1:0]         dp_port,
  input  logic [DP_W*TAG_W-1:0]          dp_src1,
  input  logic [DP_W*TAG_W-1:0]          dp_src2,
  input  logic [DP_W-1:0]                dp_rdy1,
  input  logic [DP_W-1:0]                dp_rdy2,
  input  logic [DP_W*TAG_W-1:0]          dp_dst,
  input  logic [DP_W*ROB_W-1:0]          dp_rob,
  input  logic [DP_W-1:0]                dp_sb,
  input  logic [DP_W*PAYLOAD_W-1:0]      dp_payload,
  output logic                           dp_ready,
  output logic [IQ_SEL:0]                free_cnt,
  input  logic [WB_W-1:0]                wb_valid,
  input  logic [WB_W*TAG_W-1:0]          wb_tag,
  input  logic                           prmiss,
  input  logic [ROB_W-1:0]               prmiss_rob,
  input  logic                           prmiss_sb,
  output logic [ISSUE_W-1:0]             iss_valid,
  output logic [ISSUE_W*TAG_W-1:0]       iss_src1,
  output logic [ISSUE_W*TAG_W-1:0]       iss_src2,
  output logic [ISSUE_W*TAG_W-1:0]       iss_dst,
  output logic [ISSUE_W*ROB_W-1:0]       iss_rob,
  output logic [ISSUE_W*PAYLOAD_W-1:0]   iss_payload
);

  logic [IQ_ENT-1:0]    vld_q, rdy1_q, rdy2_q, sb_q;
  logic [TAG_W-1:0]     src1_q [IQ_ENT];
  logic [TAG_W-1:0]     src2_q [IQ_ENT];
  logic [TAG_W-1:0]     dst_q  [IQ_ENT];
  logic [ROB_W-1:0]     rob_q  [IQ_ENT];
  logic [PORT_W-1:0]    port_q [IQ_ENT];
  logic [PAYLOAD_W-1:0] pl_q   [IQ_ENT];

  logic [IQ_ENT-1:0]    wake1, wake2, req, kill, issued, taken, vld_n;
  logic [DP_W-1:0]      dp_hit1, dp_hit2, alloc_ok;
  logic [IQ_SEL-1:0]    alloc_idx [DP_W];
  logic [ISSUE_W-1:0]   gnt, iss_fire;
  logic [IQ_SEL-1:0]    gidx [ISSUE_W];
  logic [IQ_SEL:0]      free_n;
  logic                 alloc_en;

  // a older than b: same sort bit -> smaller rob is older; differing bits -> wrapped, larger rob is older
  function automatic logic is_older(input logic a_sb, input logic [ROB_W-1:0] a_rob,
                                    input logic b_sb, input logic [ROB_W-1:0] b_rob);
    return (a_sb == b_sb) ? (a_rob < b_rob) : (a_rob > b_rob);
  endfunction

  assign dp_ready = (free_cnt >= (IQ_SEL+1)'(DP_W));
  assign alloc_en = dp_ready && !prmiss;

  always_comb begin
    wake1   = '0;
    wake2   = '0;
    dp_hit1 = '0;
    dp_hit2 = '0;
    for (int unsigned w = 0; w < WB_W; w++) begin
      for (int unsigned i = 0; i < IQ_ENT; i++) begin
        if (wb_valid[w] && wb_tag[w*TAG_W +: TAG_W] == src1_q[i]) wake1[i] = 1'b1;
        if (wb_valid[w] && wb_tag[w*TAG_W +: TAG_W] == src2_q[i]) wake2[i] = 1'b1;
      end
      for (int unsigned k = 0; k < DP_W; k++) begin
        if (wb_valid[w] && wb_tag[w*TAG_W +: TAG_W] == dp_src1[k*TAG_W +: TAG_W]) dp_hit1[k] = 1'b1;
        if (wb_valid[w] && wb_tag[w*TAG_W +: TAG_W] == dp_src2[k*TAG_W +: TAG_W]) dp_hit2[k] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < IQ_ENT; i++) begin
      req[i]  = vld_q[i] && rdy1_q[i] && rdy2_q[i];
      kill[i] = prmiss && vld_q[i] && is_older(prmiss_sb, prmiss_rob, sb_q[i], rob_q[i]);
    end
  end

  always_comb begin
    gnt = '0;
    for (int unsigned p = 0; p < ISSUE_W; p++) begin
      gidx[p] = '0;
      for (int unsigned i = 0; i < IQ_ENT; i++) begin
        if (req[i] && port_q[i] == PORT_W'(p)) begin
`ifdef IQ_AGE_SELECT_EN
          if (!gnt[p] || is_older(sb_q[i], rob_q[i], sb_q[gidx[p]], rob_q[gidx[p]])) begin
`else
          if (!gnt[p]) begin
`endif
            gnt[p]  = 1'b1;
            gidx[p] = IQ_SEL'(i);
          end
        end
      end
    end
  end

  always_comb begin
    issued = '0;
    for (int unsigned p = 0; p < ISSUE_W; p++) begin
      iss_fire[p] = gnt[p] && !kill[gidx[p]];
      if (iss_fire[p]) issued[gidx[p]] = 1'b1;
    end
  end

  // Each valid lane claims the lowest free entry not already claimed by an earlier lane
  always_comb begin
    taken    = '0;
    alloc_ok = '0;
    for (int unsigned k = 0; k < DP_W; k++) begin
      alloc_idx[k] = '0;
      if (dp_valid[k] && alloc_en) begin
        for (int unsigned i = 0; i < IQ_ENT; i++) begin
          if (!vld_q[i] && !taken[i] && !alloc_ok[k]) begin
            alloc_ok[k]  = 1'b1;
            alloc_idx[k] = IQ_SEL'(i);
            taken[i]     = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    vld_n  = vld_q & ~issued & ~kill;
    for (int unsigned k = 0; k < DP_W; k++) begin
      if (alloc_ok[k]) vld_n[alloc_idx[k]] = 1'b1;
    end
    free_n = '0;
    for (int unsigned i = 0; i < IQ_ENT; i++) begin
      if (!vld_n[i]) free_n = free_n + (IQ_SEL+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      free_cnt <= (IQ_SEL+1)'(IQ_ENT);
    end else begin
      vld_q    <= vld_n;
      free_cnt <= free_n;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < IQ_ENT; i++) begin
      if (wake1[i]) rdy1_q[i] <= 1'b1;
      if (wake2[i]) rdy2_q[i] <= 1'b1;
    end
    for (int unsigned k = 0; k < DP_W; k++) begin
      if (alloc_ok[k]) begin
        rdy1_q[alloc_idx[k]] <= dp_rdy1[k] || dp_hit1[k];
        rdy2_q[alloc_idx[k]] <= dp_rdy2[k] || dp_hit2[k];
        sb_q[alloc_idx[k]]   <= dp_sb[k];
        src1_q[alloc_idx[k]] <= dp_src1[k*TAG_W +: TAG_W];
        src2_q[alloc_idx[k]] <= dp_src2[k*TAG_W +: TAG_W];
        dst_q[alloc_idx[k]]  <= dp_dst[k*TAG_W +: TAG_W];
        rob_q[alloc_idx[k]]  <= dp_rob[k*ROB_W +: ROB_W];
        port_q[alloc_idx[k]] <= dp_port[k*PORT_W +: PORT_W];
        pl_q[alloc_idx[k]]   <= dp_payload[k*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iss_valid   <= '0;
      iss_src1    <= '0;
      iss_src2    <= '0;
      iss_dst     <= '0;
      iss_rob     <= '0;
      iss_payload <= '0;
    end else begin
      iss_valid <= iss_fire;
      for (int unsigned p = 0; p < ISSUE_W; p++) begin
        if (gnt[p]) begin
          iss_src1[p*TAG_W +: TAG_W]          <= src1_q[gidx[p]];
          iss_src2[p*TAG_W +: TAG_W]          <= src2_q[gidx[p]];
          iss_dst[p*TAG_W +: TAG_W]           <= dst_q[gidx[p]];
          iss_rob[p*ROB_W +: ROB_W]           <= rob_q[gidx[p]];
          iss_payload[p*PAYLOAD_W +: PAYLOAD_W] <= pl_q[gidx[p]];
        end
      end
    end
  end

  dispatch_when_full: assert property (@(posedge clk) disable iff (reset)
    !((|dp_valid) && !dp_ready));

endmodule
